// File: rtl/matrix_operand_loader_pkg.sv
// Shared types and constants for the matrix operand loader and its address generator.
package matrix_operand_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EMIT,
    DONE
  } state_e;

  // Packing slot order inside a beat; also the issue order within ISSUE (k).
  localparam logic [1:0] SLOT_A0 = 2'd0;
  localparam logic [1:0] SLOT_A1 = 2'd1;
  localparam logic [1:0] SLOT_B0 = 2'd2;
  localparam logic [1:0] SLOT_B1 = 2'd3;

  function automatic int beat_count(input int n);
    return (n * n) / 2;
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// RAM read port plus beat output port of the operand loader.
interface matrix_operand_loader_if #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int ADDR_WIDTH   = 8
);
  logic                          mem_rd;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_rdata;
  logic                          out_ready;
  logic                          read_en;
  logic [NUM_ELEMENTS*WIDTH-1:0] rdata;

  modport master (
    output mem_rd, mem_addr, read_en, rdata,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, read_en, rdata,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/matrix_operand_loader_addr_gen.sv
// Row-major element address: base + (r + row_ofs)*N + c, wrapping at 2^ADDR_WIDTH.
module operand_addr_gen
  import matrix_operand_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int MATRIX_WIDTH = 4,
  localparam int RW          = $clog2(MATRIX_WIDTH)
) (
  input  logic [RW-1:0]         r_i,
  input  logic [RW-1:0]         c_i,
  input  logic [1:0]            k_i,
  input  logic [ADDR_WIDTH-1:0] a_base_i,
  input  logic [ADDR_WIDTH-1:0] b_base_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  logic                  sel_b;
  logic                  odd_row;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] row;

  assign sel_b   = (k_i == SLOT_B0) || (k_i == SLOT_B1);
  assign odd_row = (k_i == SLOT_A1) || (k_i == SLOT_B1);
  assign base    = sel_b ? b_base_i : a_base_i;
  assign row     = ADDR_WIDTH'(r_i) + ADDR_WIDTH'(odd_row);
  assign addr_o  = base + row * ADDR_WIDTH'(MATRIX_WIDTH) + ADDR_WIDTH'(c_i);
endmodule

// File: rtl/matrix_operand_loader.sv
// Reads A and B from word RAM and emits 4-element beats {A[r][c],A[r+1][c],B[r][c],B[r+1][c]},
// column-outer / row-pair-inner, with out_ready back-pressure.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MATRIX_WIDTH = 4,
  parameter int NUM_ELEMENTS = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int A_BASE       = 0,
  parameter int B_BASE       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  matrix_operand_loader_if.master   bus
);
  localparam int RW    = $clog2(MATRIX_WIDTH);
  localparam int BEATS = beat_count(MATRIX_WIDTH);
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [RW-1:0]         R_LAST = RW'(MATRIX_WIDTH - 2);
  localparam logic [BW-1:0]         B_LAST = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ADDR = ADDR_WIDTH'(A_BASE);
  localparam logic [ADDR_WIDTH-1:0] B_ADDR = ADDR_WIDTH'(B_BASE);

  state_e                             state_q, state_d;
  logic [RW-1:0]                      r_q, r_d;
  logic [RW-1:0]                      c_q, c_d;
  logic [1:0]                         k_q, k_d;
  logic [BW-1:0]                      beat_q, beat_d;
  logic [NUM_ELEMENTS-1:0][WIDTH-1:0] slot_q, slot_d;
  logic [ADDR_WIDTH-1:0]              gen_addr;

  operand_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MATRIX_WIDTH (MATRIX_WIDTH)
  ) u_addr_gen (
    .r_i      (r_q),
    .c_i      (c_q),
    .k_i      (k_q),
    .a_base_i (A_ADDR),
    .b_base_i (B_ADDR),
    .addr_o   (gen_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      beat_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    beat_d  = beat_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          beat_d  = '0;
        end
      end
      ISSUE: begin
        // RAM answers one cycle late, so this cycle's data belongs to the previous issue.
        if (k_q != SLOT_A0) slot_d[k_q - 2'd1] = bus.mem_rdata;
        k_d = k_q + 2'd1;
        if (k_q == SLOT_B1) state_d = DRAIN;
      end
      DRAIN: begin
        slot_d[SLOT_B1] = bus.mem_rdata;
        state_d         = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == B_LAST) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            k_d     = '0;
            if (r_q == R_LAST) begin
              r_d = '0;
              c_d = c_q + 1'b1;
            end else begin
              r_d = r_q + RW'(2);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy is already low while done pulses, so the controller sees a clean hand-back.
  assign busy_o       = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == EMIT);
  assign done_o       = (state_q == DONE);
  assign bus.mem_rd   = (state_q == ISSUE);
  assign bus.mem_addr = bus.mem_rd ? gen_addr : '0;
  assign bus.read_en  = (state_q == EMIT) && bus.out_ready;
  assign bus.rdata    = {slot_q[SLOT_A0], slot_q[SLOT_A1], slot_q[SLOT_B0], slot_q[SLOT_B1]};

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench: default instance for data/handshake, second instance for address wrap.
module tb_matrix_operand_loader;
  logic clk;
  logic reset;
  logic start, busy, done;
  logic start2, busy2, done2;

  matrix_operand_loader_if #(.WIDTH(8), .NUM_ELEMENTS(4), .ADDR_WIDTH(8)) bus ();
  matrix_operand_loader_if #(.WIDTH(8), .NUM_ELEMENTS(4), .ADDR_WIDTH(8)) bus2 ();

  matrix_operand_loader dut (
    .clk(clk), .reset(reset), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
  );

  matrix_operand_loader #(.A_BASE(8'h40), .B_BASE(8'hF8)) dut2 (
    .clk(clk), .reset(reset), .start_i(start2), .busy_o(busy2), .done_o(done2), .bus(bus2)
  );

  logic [7:0]  ram [256];
  logic [31:0] beats [$];
  logic [7:0]  addr2 [$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_re = 0, done_cyc = 0, done_n = 0, rd_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd)  bus.mem_rdata  <= ram[bus.mem_addr];
    if (bus2.mem_rd) bus2.mem_rdata <= ram[bus2.mem_addr];
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.read_en) begin
      beats.push_back(bus.rdata);
      last_re = cyc;
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    if (bus.mem_rd)  rd_n = rd_n + 1;
    if (bus2.mem_rd) addr2.push_back(bus2.mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int b0, b1, d0, r0, n, ok, g;
    bit p1, p5;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ram[i*4 + j]      = 8'(i*4 + j + 1);
        ram[16 + i*4 + j] = 8'(8'h80 + i*4 + j + 1);
      end

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;
    tick(); tick();
    chk("rst_busy",    busy,         1'b0);
    chk("rst_done",    done,         1'b0);
    chk("rst_mem_rd",  bus.mem_rd,   1'b0);
    chk("rst_addr",    bus.mem_addr, 8'h00);
    chk("rst_rdata",   bus.rdata,    32'h0);
    chk("rst_read_en", bus.read_en,  1'b0);
    reset = 1'b0;
    tick();

    // 1: basic load
    b0 = beats.size(); d0 = done_n; r0 = rd_n;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy",   busy,         1'b1);
    chk("t1_mem_rd", bus.mem_rd,   1'b1);
    chk("t1_addr0",  bus.mem_addr, 8'h00);
    wait_done(100, n);
    chk("t1_done_seen",   done, 1'b1);
    chk("t1_busy_in_done", busy, 1'b0);
    chk("t1_latency",     n,    48);
    tick();
    chk("t1_done_gap",   done_cyc - last_re, 1);
    chk("t1_done_drop",  done,               1'b0);
    chk("t1_done_count", done_n - d0,        1);
    chk("t1_beats",      beats.size() - b0,  8);
    chk("t1_reads",      rd_n - r0,          32);
    chk("t1_beat0", beats[b0],     32'h01058185);
    chk("t1_beat1", beats[b0 + 1], 32'h090D898D);
    chk("t1_beat4", beats[b0 + 4], 32'h03078387);
    chk("t1_beat7", beats[b0 + 7], 32'h0C108C90);

    // 2: back-pressure on beat index 2
    b0 = beats.size(); d0 = done_n; r0 = rd_n;
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (beats.size() - b0 < 2 && g < 100) begin tick(); g++; end
    bus.out_ready = 1'b0;
    repeat (5) tick();
    n = rd_n; ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rdata === 32'h02068286 && bus.read_en === 1'b0) ok++;
      tick();
    end
    chk("t2_hold_cycles", ok,                10);
    chk("t2_no_reads",    rd_n - n,          0);
    chk("t2_no_xfer",     beats.size() - b0, 2);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_xfer_once", beats.size() - b0, 3);
    chk("t2_beat2",     beats[b0 + 2],     32'h02068286);
    wait_done(100, n);
    chk("t2_done_seen", done, 1'b1);
    tick();
    chk("t2_beats", beats.size() - b0, 8);
    chk("t2_done",  done_n - d0,       1);
    chk("t2_reads", rd_n - r0,         32);

    // 3: address generation with wrapping bases
    b0 = addr2.size();
    start2 = 1'b1; tick(); start2 = 1'b0;
    g = 0;
    while (!done2 && g < 100) begin tick(); g++; end
    chk("t3_done_seen", done2, 1'b1);
    tick();
    chk("t3_reads", addr2.size() - b0, 32);
    chk("t3_a00",   addr2[b0],      8'h40);
    chk("t3_b10",   addr2[b0 + 3],  8'hFC);
    chk("t3_a20",   addr2[b0 + 4],  8'h48);
    chk("t3_b33",   addr2[b0 + 31], 8'h07);

    // 4: reset during EMIT of beat index 3
    b0 = beats.size();
    start = 1'b1; tick(); start = 1'b0;
    g = 0;
    while (beats.size() - b0 < 3 && g < 100) begin tick(); g++; end
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("t4_emit_rdata", bus.rdata,   32'h0A0E8A8E);
    chk("t4_emit_hold",  bus.read_en, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.out_ready = 1'b1;
    d0 = done_n;
    chk("t4_busy",    busy,        1'b0);
    chk("t4_read_en", bus.read_en, 1'b0);
    chk("t4_mem_rd",  bus.mem_rd,  1'b0);
    chk("t4_rdata",   bus.rdata,   32'h0);
    chk("t4_done",    done,        1'b0);
    repeat (3) tick();
    chk("t4_no_done", done_n - d0, 0);
    chk("t4_idle",    busy,        1'b0);
    b0 = beats.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(100, n);
    chk("t4_done_seen", done, 1'b1);
    tick();
    chk("t4_beats", beats.size() - b0, 8);
    chk("t4_beat0", beats[b0],         32'h01058185);

    // 5: start while busy, and in the DONE cycle
    b0 = beats.size(); d0 = done_n;
    start = 1'b1; tick(); start = 1'b0;
    p1 = 1'b0; p5 = 1'b0; n = 0;
    while (!done && n < 100) begin
      if (!p1 && beats.size() - b0 == 1) begin start = 1'b1; p1 = 1'b1; end
      else if (!p5 && beats.size() - b0 == 5) begin start = 1'b1; p5 = 1'b1; end
      else start = 1'b0;
      tick();
      n++;
    end
    chk("t5_done_seen", done, 1'b1);
    start = 1'b1;
    tick();
    chk("t5_done_start_ignored", busy,       1'b0);
    chk("t5_idle_no_read",       bus.mem_rd, 1'b0);
    tick();
    start = 1'b0;
    chk("t5_restart_busy", busy,              1'b1);
    chk("t5_beats",        beats.size() - b0, 8);
    chk("t5_done_count",   done_n - d0,       1);
    b1 = beats.size();
    wait_done(100, n);
    chk("t5_done2_seen", done, 1'b1);
    tick();
    chk("t5_beats2",  beats.size() - b1, 8);
    chk("t5_b2beat0", beats[b1],         32'h01058185);
    chk("t5_b2beat7", beats[b1 + 7],     32'h0C108C90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
